// File: rtl/raytracing_line_dispatcher_if.sv
// Bundle between the line dispatcher, its raytracing workers and the
// downstream frame-buffer writer.
interface raytracing_line_dispatcher_if #(
    parameter int N_WORKERS        = 10,
    parameter int JOBS_SUBDIVISION = 64,
    parameter int COLOR_B          = 12
);
    logic                                          frame_start;
    logic [N_WORKERS-1:0]                          activate;
    logic [N_WORKERS*12-1:0]                       pixel_start_x;
    logic signed [9:0]                             pixel_y;
    logic [16:0]                                   pixel_y_sqrd;
    logic [N_WORKERS-1:0]                          worker_busy;
    logic [N_WORKERS*JOBS_SUBDIVISION*COLOR_B-1:0] worker_buffer;
    logic                                          px_valid;
    logic                                          px_ready;
    logic [COLOR_B-1:0]                            px_data;
    logic [9:0]                                    px_x;
    logic [8:0]                                    px_y;
    logic                                          frame_busy;
    logic                                          frame_done;

    modport master (
        input  frame_start, worker_busy, worker_buffer, px_ready,
        output activate, pixel_start_x, pixel_y, pixel_y_sqrd,
               px_valid, px_data, px_x, px_y, frame_busy, frame_done
    );

    modport slave (
        output frame_start, worker_busy, worker_buffer, px_ready,
        input  activate, pixel_start_x, pixel_y, pixel_y_sqrd,
               px_valid, px_data, px_x, px_y, frame_busy, frame_done
    );
endinterface

// File: rtl/raytracing_line_dispatcher.sv
// Launches the raytracing workers one line at a time and streams their
// result buffers out as a raster-ordered pixel stream.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for frame_start
// S_LAUNCH    | load pixel_y / pixel_y_sqrd for the current line
// S_ARM       | activate high, wait (>= 2 cycles) for every worker busy
// S_WAIT_DONE | activate high, wait for every worker to drop busy
// S_DRAIN     | stream 640 pixels of the line, activate held so buffers hold
// S_RELEASE   | activate low one cycle, then next line or frame done
module raytracing_line_dispatcher #(
    parameter int N_WORKERS        = 10,
    parameter int JOBS_SUBDIVISION = 64,
    parameter int LINES            = 480,
    parameter int COLOR_B          = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    raytracing_line_dispatcher_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT_DONE,
        S_DRAIN,
        S_RELEASE
    } state_t;

    localparam int LINE_PIXELS = N_WORKERS * JOBS_SUBDIVISION;
    localparam int WK_W        = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int JOB_W       = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
    localparam int SLOT_W      = $clog2(LINE_PIXELS);
    localparam int ARM_CYCLES  = 2;

    localparam logic [9:0]      X_LAST    = 10'(LINE_PIXELS - 1);
    localparam logic [8:0]      LINE_LAST = 9'(LINES - 1);
    localparam logic [WK_W-1:0] WK_LAST   = WK_W'(N_WORKERS - 1);
    localparam logic [1:0]      ARM_LOAD  = 2'(ARM_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [8:0]          r_line;
    logic [9:0]          r_x;
    logic [WK_W-1:0]     r_wk;
    logic [JOB_W-1:0]    r_job;
    logic [1:0]          r_arm_cnt;
    logic signed [9:0]   r_pixel_y;
    logic [16:0]         r_pixel_y_sqrd;
    logic                r_frame_busy;
    logic                r_frame_done;

    logic                w_all_busy;
    logic                w_all_idle;
    logic                w_xfer;
    logic                w_last_px;
    logic signed [9:0]   w_y_nxt;
    logic signed [16:0]  w_y_ext;
    logic [16:0]         w_y_sq;
    logic [SLOT_W-1:0]   w_slot;
    logic [COLOR_B-1:0]  w_buf [LINE_PIXELS];

    for (genvar g = 0; g < LINE_PIXELS; g++) begin : g_buf
        assign w_buf[g] = bus.worker_buffer[g*COLOR_B +: COLOR_B];
    end

    for (genvar g = 0; g < N_WORKERS; g++) begin : g_start_x
        assign bus.pixel_start_x[g*12 +: 12] = 12'(g - 320);
    end

    assign w_all_busy = &bus.worker_busy;
    assign w_all_idle = ~|bus.worker_busy;
    assign w_xfer     = (r_state == S_DRAIN) && bus.px_ready;
    assign w_last_px  = (r_x == X_LAST);

    // Line y is centred on the screen; square is taken on a sign-extended copy
    // so the 17-bit product keeps the right low bits without a wider temporary.
    assign w_y_nxt = 10'sd240 - $signed({1'b0, r_line});
    assign w_y_ext = {{7{w_y_nxt[9]}}, w_y_nxt};
    assign w_y_sq  = w_y_ext * w_y_ext;

    // Pixel x maps to worker x%N, job x/N; both tracked by the wrap counters.
    assign w_slot = SLOT_W'(r_wk) * SLOT_W'(JOBS_SUBDIVISION) + SLOT_W'(r_job);

    assign bus.px_data      = w_buf[w_slot];
    assign bus.px_x         = r_x;
    assign bus.px_y         = r_line;
    assign bus.pixel_y      = r_pixel_y;
    assign bus.pixel_y_sqrd = r_pixel_y_sqrd;
    assign bus.frame_busy   = r_frame_busy;
    assign bus.frame_done   = r_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_line         <= '0;
            r_x            <= '0;
            r_wk           <= '0;
            r_job          <= '0;
            r_arm_cnt      <= '0;
            r_pixel_y      <= '0;
            r_pixel_y_sqrd <= '0;
            r_frame_busy   <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_line       <= '0;
                        r_frame_busy <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    r_pixel_y      <= w_y_nxt;
                    r_pixel_y_sqrd <= w_y_sq;
                    r_arm_cnt      <= ARM_LOAD;
                end
                S_ARM: begin
                    if (r_arm_cnt != 2'd0) begin
                        r_arm_cnt <= r_arm_cnt - 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        if (w_last_px) begin
                            r_x   <= '0;
                            r_wk  <= '0;
                            r_job <= '0;
                        end else begin
                            r_x <= r_x + 10'd1;
                            if (r_wk == WK_LAST) begin
                                r_wk  <= '0;
                                r_job <= r_job + JOB_W'(1);
                            end else begin
                                r_wk <= r_wk + WK_W'(1);
                            end
                        end
                    end
                end
                S_RELEASE: begin
                    if (r_line == LINE_LAST) begin
                        r_line       <= '0;
                        r_frame_busy <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_line <= r_line + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.activate = '0;
        bus.px_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.frame_start) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_ARM;
            end
            S_ARM: begin
                bus.activate = '1;
                if ((r_arm_cnt == 2'd0) && w_all_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                bus.activate = '1;
                if (w_all_idle) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                bus.activate = '1;
                bus.px_valid = 1'b1;
                if (w_xfer && w_last_px) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = (r_line == LINE_LAST) ? S_IDLE : S_LAUNCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
